// File: rtl/wb_font_fetch_pkg.sv
// rtl/wb_font_fetch_pkg.sv - shared types and constants for the font-ROM glyph fetcher
package wb_font_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EN_WR,
    ST_ADR_WR,
    ST_WAIT,
    ST_DAT_RD,
    ST_PUSH,
    ST_DIS_WR
  } state_e;

  localparam logic [31:0] REG_RD   = 32'h0000_0000;
  localparam logic [31:0] REG_ADDR = 32'h0000_0004;
  localparam logic [31:0] REG_DOUT = 32'h0000_0008;

  localparam int GLYPH_ROWS = 8;
  localparam int ADDR_RD_W  = 10;

  // Font ROM holds 8 consecutive bytes per character
  function automatic logic [ADDR_RD_W-1:0] rom_addr(input logic [6:0] code, input logic [2:0] row);
    return {code, row};
  endfunction

endpackage

// File: rtl/wb_font_fetch_if.sv
// rtl/wb_font_fetch_if.sv - Wishbone bus bundle between the glyph fetcher and the font slave
interface wb_font_fetch_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - single-access Wishbone master with registered outputs and ack timeout
module wb_master_port #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_i,
  input  logic         req_we_i,
  input  logic [31:0]  req_adr_i,
  input  logic [31:0]  req_dat_i,
  output logic         done_o,
  output logic         timeout_o,
  output logic [7:0]   rdata_o,
  wb_font_fetch_if.master wb
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        unused_dat;

  assign done_o     = cyc_q & wb.wb_ack_i;
  assign timeout_o  = cyc_q & ~wb.wb_ack_i & (cnt_q == TO_LAST);
  assign rdata_o    = wb.wb_dat_i[7:0];
  assign unused_dat = ^wb.wb_dat_i[31:8];

  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (!cyc_q) begin
      if (req_i) begin
        cyc_d = 1'b1;
        we_d  = req_we_i;
        adr_d = req_adr_i;
        dat_d = req_dat_i;
        sel_d = 4'hF;
        cnt_d = 8'd0;
      end
    end else if (wb.wb_ack_i || cnt_q == TO_LAST) begin
      // Dropping on the ack edge guarantees an idle cycle before the next access
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = 32'd0;
      dat_d = 32'd0;
      sel_d = 4'h0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 32'd0;
      dat_q <= 32'd0;
      sel_q <= 4'h0;
      cnt_q <= 8'd0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;

endmodule

// File: rtl/wb_font_fetch.sv
// rtl/wb_font_fetch.sv - fetches the 8 rows of one glyph from the font-ROM slave and streams them out
module wb_font_fetch
  import wb_font_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          ROM_WAIT    = 2,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [6:0] char_code,
  output logic       char_ready,
  output logic       row_valid,
  input  logic       row_ready,
  output logic [7:0] row_data,
  output logic [2:0] row_idx,
  output logic       row_last,
  output logic       busy,
  output logic       err,
  wb_font_fetch_if.master wb
);

  localparam logic [3:0] WAIT_LAST = 4'((ROM_WAIT == 0) ? 0 : ROM_WAIT - 1);
  localparam logic [2:0] LAST_ROW  = 3'(GLYPH_ROWS - 1);

  state_e      state_q, state_d;
  logic [6:0]  code_q, code_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        run_q;

  logic        req, req_we, done, timeout;
  logic [31:0] req_adr, req_dat;
  logic [7:0]  rdata;

  wb_master_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .req_we_i  (req_we),
    .req_adr_i (req_adr),
    .req_dat_i (req_dat),
    .done_o    (done),
    .timeout_o (timeout),
    .rdata_o   (rdata),
    .wb        (wb)
  );

  // The port ignores req while an access is open, so holding req for a whole state is safe
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    row_d   = row_q;
    data_d  = data_q;
    wait_d  = wait_q;
    err_d   = err_q;
    req     = 1'b0;
    req_we  = 1'b0;
    req_adr = 32'd0;
    req_dat = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (run_q && char_valid) begin
          code_d  = char_code;
          row_d   = 3'd0;
          err_d   = 1'b0;
          state_d = ST_EN_WR;
        end
      end
      ST_EN_WR: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = BASE_ADR + REG_RD;
        req_dat = 32'd1;
        if (done) state_d = ST_ADR_WR;
      end
      ST_ADR_WR: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = BASE_ADR + REG_ADDR;
        req_dat = {22'd0, rom_addr(code_q, row_q)};
        if (done) begin
          wait_d  = 4'd0;
          state_d = (ROM_WAIT == 0) ? ST_DAT_RD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_DAT_RD;
        else wait_d = wait_q + 4'd1;
      end
      ST_DAT_RD: begin
        req     = 1'b1;
        req_adr = BASE_ADR + REG_DOUT;
        if (done) begin
          data_d  = rdata;
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (row_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_DIS_WR;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = ST_ADR_WR;
          end
        end
      end
      ST_DIS_WR: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = BASE_ADR + REG_RD;
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A stuck slave abandons the glyph without trying to disable the ROM
    if (timeout) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      code_q  <= 7'd0;
      row_q   <= 3'd0;
      data_q  <= 8'd0;
      wait_q  <= 4'd0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      row_q   <= row_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  assign char_ready = run_q && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign row_valid  = (state_q == ST_PUSH);
  assign row_data   = data_q;
  assign row_idx    = row_q;
  assign row_last   = (state_q == ST_PUSH) && (row_q == LAST_ROW);
  assign err        = err_q;

endmodule

// File: tb/tb_wb_font_fetch.sv
// tb/tb_wb_font_fetch.sv - self-checking bench for wb_font_fetch against a font-ROM slave model
module tb_wb_font_fetch;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
    logic       last;
  } row_t;

  typedef struct {
    logic [6:0] code;
    logic [9:0] base;
    bit         pulse;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       char_valid = 1'b0;
  logic [6:0] char_code = 7'd0;
  logic       char_ready, row_valid, row_last, busy, err;
  logic       row_ready = 1'b1;
  logic [7:0] row_data;
  logic [2:0] row_idx;

  logic       ack_q = 1'b0;
  logic       block_en = 1'b0;
  logic [9:0] rom_adr = 10'd0;

  int checks = 0;
  int failures = 0;

  bus_t bus_log[$];
  row_t row_log[$];
  vec_t vecs[3];

  wb_font_fetch_if wb ();

  wb_font_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .row_last   (row_last),
    .busy       (busy),
    .err        (err),
    .wb         (wb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom8(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], a[2:0], 3'b101};
  endfunction

  // Slave with stb&cyc&registered-ack; upper read bits carry junk that must be ignored
  always @(posedge clk) begin
    ack_q <= wb.wb_cyc_o & wb.wb_stb_o & ~ack_q & ~(block_en && wb.wb_adr_o == 32'h4);
    if (wb.wb_ack_i && wb.wb_we_o && wb.wb_adr_o == 32'h4) rom_adr <= wb.wb_dat_o[9:0];
  end
  assign wb.wb_ack_i = ack_q & wb.wb_cyc_o & wb.wb_stb_o;
  assign wb.wb_dat_i = {24'hC3C3C3, rom8(rom_adr)};

  always @(negedge clk) begin
    if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i)
      bus_log.push_back('{wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o});
    if (row_valid && row_ready)
      row_log.push_back('{row_idx, row_data, row_last});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_char(input logic [6:0] code);
    bus_log.delete();
    row_log.delete();
    @(posedge clk); #1;
    check("ready_before_req", 32'(char_ready), 32'd1);
    char_valid = 1'b1;
    char_code  = code;
    @(posedge clk); #1;
    char_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_in_budget", 32'(busy), 32'd0);
  endtask

  task automatic check_glyph(input logic [9:0] base);
    check("bus_count", 32'(bus_log.size()), 32'd18);
    for (int i = 0; i < bus_log.size() && i < 18; i++) begin
      if (i == 0 || i == 17) begin
        check("en_dis_we", 32'(bus_log[i].we), 32'd1);
        check("en_dis_adr", bus_log[i].adr, 32'h0);
        check("en_dis_dat", bus_log[i].dat, (i == 0) ? 32'd1 : 32'd0);
      end else if (i % 2 == 1) begin
        check("addr_wr_we", 32'(bus_log[i].we), 32'd1);
        check("addr_wr_adr", bus_log[i].adr, 32'h4);
        check("addr_wr_dat", bus_log[i].dat, 32'(base) + 32'((i - 1) / 2));
      end else begin
        check("dout_rd_we", 32'(bus_log[i].we), 32'd0);
        check("dout_rd_adr", bus_log[i].adr, 32'h8);
      end
    end
    check("row_count", 32'(row_log.size()), 32'd8);
    for (int r = 0; r < row_log.size() && r < 8; r++) begin
      check("row_idx", 32'(row_log[r].idx), 32'(r));
      check("row_last", 32'(row_log[r].last), (r == 7) ? 32'd1 : 32'd0);
      check("row_data", 32'(row_log[r].data), 32'(rom8(base + 10'(r))));
    end
    check("err_after_glyph", 32'(err), 32'd0);
  endtask

  task automatic run_glyph(input logic [6:0] code, input logic [9:0] base, input bit pulse);
    start_char(code);
    if (pulse) begin
      repeat (10) @(posedge clk);
      #1 char_valid = 1'b1;
      char_code = code ^ 7'h2A;
      check("ready_low_busy", 32'(char_ready), 32'd0);
      @(posedge clk); #1 char_valid = 1'b0;
    end
    wait_idle(500);
    repeat (3) @(negedge clk);
    check("no_extra_start", 32'(busy), 32'd0);
    check_glyph(base);
  endtask

  initial begin
    vecs[0] = '{7'h41, 10'h208, 1'b1};
    vecs[1] = '{7'h00, 10'h000, 1'b0};
    vecs[2] = '{7'h7F, 10'h3F8, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_char_ready", 32'(char_ready), 32'd0);
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_row_data", 32'(row_data), 32'd0);
    check("rst_row_idx_last", 32'({row_idx, row_last}), 32'd0);
    check("rst_busy_err", 32'({busy, err}), 32'd0);
    check("rst_cyc_stb_we", 32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}), 32'd0);
    check("rst_adr", wb.wb_adr_o, 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb.wb_sel_o), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(char_ready), 32'd1);

    for (int v = 0; v < 3; v++) run_glyph(vecs[v].code, vecs[v].base, vecs[v].pulse);

    // Backpressure on row 3: output held, bus quiet
    row_ready = 1'b0;
    start_char(7'h41);
    for (int r = 0; r < 8; r++) begin
      int n;
      logic [7:0] saved;
      n = 0;
      while (!row_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("row_valid_in_budget", 32'(row_valid), 32'd1);
      if (!row_valid) break;
      if (r == 3) begin
        saved = row_data;
        repeat (5) begin
          @(negedge clk);
          check("bp_valid_held", 32'(row_valid), 32'd1);
          check("bp_data_stable", 32'(row_data), 32'(saved));
          check("bp_bus_quiet", 32'(wb.wb_cyc_o), 32'd0);
        end
      end
      @(posedge clk); #1 row_ready = 1'b1;
      @(posedge clk); #1 row_ready = 1'b0;
    end
    row_ready = 1'b1;
    wait_idle(200);
    check_glyph(10'h208);

    // Slave never acks the address write
    block_en = 1'b1;
    start_char(7'h05);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!busy) break;
        if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_adr_o == 32'h4) n++;
      end
      check("timeout_strobe_cycles", 32'(n), 32'd16);
    end
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_cyc_dropped", 32'(wb.wb_cyc_o), 32'd0);
    check("timeout_no_row", 32'(row_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    block_en = 1'b0;
    run_glyph(7'h41, 10'h208, 1'b0);

    // Reset while the d_out read is in flight
    start_char(7'h10);
    begin
      int n;
      n = 0;
      while (!(wb.wb_cyc_o && wb.wb_adr_o == 32'h8) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reached_dat_rd", 32'(wb.wb_cyc_o && wb.wb_adr_o == 32'h8), 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("async_cyc_stb", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'd0);
    check("async_row_valid", 32'(row_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_sel", 32'(wb.wb_sel_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_glyph(7'h20, 10'h100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_font_fetch.md
Name: wb_font_fetch

Overview:
- Wishbone master that reads glyph bitmaps out of the font-ROM Wishbone slave (registers: rd enable 0x00, addr_rd 0x04, d_out 0x08).
- Accepts one character code and runs the register write/read sequence for each of the 8 glyph rows.
- Streams each row byte to the LCD pixel path through a valid/ready handshake.
- Sits between the text/cursor logic and the LCD painter.

Parameters:
- BASE_ADR, 32'h0000_0000, byte base address of the font slave.
- ROM_WAIT, 2, idle cycles between the addr_rd write ack and the d_out read strobe (covers ROM latency); legal range 0..15.
- ACK_TIMEOUT, 16, max cycles a strobe waits for wb_ack_i before abort; legal range 2..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- char_valid  in  1  character request valid
- char_code  in  7  character code (0..127)
- char_ready  out  1  high only in IDLE
- row_valid  out  1  row byte available
- row_ready  in  1  consumer accepts row
- row_data  out  8  glyph row bits, bit7 = leftmost pixel
- row_idx  out  3  row number 0..7
- row_last  out  1  high with row_idx==7
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky ack-timeout flag
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  address
- wb_sel_o  out  4  byte selects; always 4'hF during strobes
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data; only [7:0] used
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset:
  - Asserts asynchronously when reset=0 and releases on a clk edge.
  - All outputs 0 in reset except wb_sel_o=4'h0; state=IDLE; err=0.
- Bus rule:
  - cyc/stb/we/adr/dat/sel are registered and held constant until the first clk edge that samples wb_ack_i=1.
  - On that edge cyc and stb drop to 0, giving at least one idle cycle between accesses.
  - This matches a slave whose ack is stb&cyc&registered-ack.
- States:
  - IDLE: char_ready=1. On char_valid, latch code, clear err, row=0, go to EN_WR.
  - EN_WR: write adr=BASE+0x00, dat=1.
  - ADR_WR: write adr=BASE+0x04, dat={22'b0, code, row}.
    - ROM address = code*8+row.
  - WAIT: count ROM_WAIT cycles (0 means skip) and go to DAT_RD.
  - DAT_RD: read adr=BASE+0x08, we=0. On ack, capture wb_dat_i[7:0] into row_data and go to PUSH.
  - PUSH: row_valid=1; row_data/row_idx/row_last stable until row_ready.
    - On the handshake, if row==7 go to DIS_WR.
    - Otherwise row+1 and go to ADR_WR.
  - DIS_WR: write adr=BASE+0x00, dat=0, then go to IDLE.
- Latency:
  - char_valid accept to first row_valid = 2 + ROM_WAIT + 2 + ack delays.
  - With a 1-cycle slave ack: 3 cycles per access (strobe, ack, gap).
- Row counter is 3 bits; the row 7→0 transition never happens inside a glyph.
- char_valid outside IDLE is ignored (char_ready=0); no queuing.
- Timeout:
  - A per-access counter starts at strobe assertion.
  - If it reaches ACK_TIMEOUT without ack: drop cyc/stb, set err=1, row_valid=0, go to IDLE directly (no DIS_WR).
  - err holds until the next accepted request.
- row_ready is ignored outside PUSH; row_valid is never asserted combinationally from row_ready.
- Reset mid-operation: bus released immediately (cyc/stb=0); any partial glyph is discarded.
- wb_dat_i[31:8] is ignored.

Decomposition:
- Shared package wb_font_pkg holds:
  - state encoding enum;
  - register offsets REG_RD=0x00, REG_ADDR=0x04, REG_DOUT=0x08;
  - GLYPH_ROWS=8;
  - address width ADDR_RD_W=10.
- One natural sub-module, wb_master_port: single-access Wishbone master (request/ack/timeout, registered outputs). The FSM in wb_font_fetch issues requests to it.

Test Plan:
- Reset with the bus idle: all outputs 0, char_ready=1 after release.
- char_code=7'h41, 1-cycle ack slave model, row_ready=1:
  - bus sequence is W 0x00←1, then 8× (W 0x04←0x208+r, R 0x08), then W 0x00←0;
  - 8 rows out, row_idx 0..7, row_last only on row 7;
  - data matches model ROM.
- Backpressure: hold row_ready=0 for 5 cycles at row 3 → row_valid stays 1, row_data stable, no bus activity, row 4 follows after release.
- Timeout: slave never acks the 0x04 write → cyc/stb drop after 16 cycles, err=1, IDLE. The next request clears err and completes.
- char_valid pulsed while busy → ignored. Codes 0x00 and 0x7F → addresses 0x000..0x007 and 0x3F8..0x3FF.
- Assert reset during DAT_RD → cyc/stb/row_valid go 0 asynchronously. After release a new request for 0x20 completes normally.
